// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
//   Shared types and sizing for the iterative radix-4 Booth multiplier.
//   - mul_state_e   : control FSM states (IDLE / BUSY / DONE)
//   - booth_digit_e : recoded Booth digit, encoded directly as {neg, one, two}
//   - N_DIGITS, EXT_W, CNT_W : sizing for the default 32-bit build
//   - booth_digit() : radix-4 recoding of one overlapping 3-bit window
//   - mul_n_digits(), mul_cnt_w() : the same sizing for any even WIDTH
// -----------------------------------------------------------------------------
package mul_pkg;

   localparam int MUL_WIDTH = 32;
   localparam int EXT_W     = MUL_WIDTH + 2;
   localparam int N_DIGITS  = EXT_W / 2;
   localparam int CNT_W     = $clog2(N_DIGITS + 1);

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_BUSY,
      MUL_DONE
   } mul_state_e;

   // Encoding is the {neg, one, two} control word, so no extra decode is needed.
   typedef enum logic [2:0] {
      BD_ZERO = 3'b000,
      BD_POS1 = 3'b010,
      BD_POS2 = 3'b001,
      BD_NEG1 = 3'b110,
      BD_NEG2 = 3'b101
   } booth_digit_e;

   // Window is {b[2i+1], b[2i], b[2i-1]}.
   function automatic booth_digit_e booth_digit(input logic [2:0] bits);
      booth_digit_e d;
      unique case (bits)
         3'b001, 3'b010: d = BD_POS1;
         3'b011:         d = BD_POS2;
         3'b100:         d = BD_NEG2;
         3'b101, 3'b110: d = BD_NEG1;
         default:        d = BD_ZERO;  // 000 and 111
      endcase
      return d;
   endfunction

   function automatic int mul_n_digits(input int width);
      return (width + 2) / 2;
   endfunction

   function automatic int mul_cnt_w(input int width);
      return $clog2(mul_n_digits(width) + 1);
   endfunction

endpackage

// File: rtl/booth_enc.sv
// -----------------------------------------------------------------------------
// booth_enc
//   Combinational radix-4 Booth recoder for one digit.
//   Ports:
//     bits  in  3  overlapping multiplier window {b[2i+1], b[2i], b[2i-1]}
//     neg   out 1  partial product is subtracted
//     one   out 1  partial product magnitude is 1x multiplicand
//     two   out 1  partial product magnitude is 2x multiplicand
// -----------------------------------------------------------------------------
module booth_enc
   import mul_pkg::*;
(
   input  logic [2:0] bits,
   output logic       neg,
   output logic       one,
   output logic       two
);

   booth_digit_e digit;

   assign digit            = booth_digit(bits);
   assign {neg, one, two}  = digit;

endmodule

// File: rtl/booth_mul.sv
// -----------------------------------------------------------------------------
// booth_mul
//   Iterative radix-4 Booth multiplier for MULT/MULTU. One Booth digit is
//   retired per cycle; the ALU holds start high until ready pulses.
//   Ports:
//     clk     in   1        core clock
//     rst     in   1        synchronous, active-high reset
//     a       in   WIDTH    multiplicand
//     b       in   WIDTH    multiplier (Booth-recoded operand)
//     sign    in   1        1 = signed (MULT), 0 = unsigned (MULTU)
//     start   in   1        level request; dropping it while busy aborts
//     result  out  2*WIDTH  product {hi, lo}, held until the next completion
//     ready   out  1        one-cycle pulse, result valid this cycle
//   Build option:
//     MUL_EARLY_TERM_EN  finish as soon as all remaining digits are zero.
//                        Undefined: fixed latency of N_DIGITS+1 cycles.
// -----------------------------------------------------------------------------
module booth_mul
   import mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 sign,
   input  logic                 start,
   output logic [2*WIDTH-1:0]   result,
   output logic                 ready
);

   localparam int PW = 2 * WIDTH;           // product / accumulator width
   localparam int XW = WIDTH + 2;           // extended operand width
   localparam int ND = mul_n_digits(WIDTH);
   localparam int CW = mul_cnt_w(WIDTH);

   mul_state_e        state;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     mcand;                // pre-shifted to the current digit weight
   logic [XW:0]       mplr;                 // {ext(b), q-1}, consumed from the bottom
   logic [CW-1:0]     count;

   logic [PW-1:0]     a_ext;
   logic [XW-1:0]     b_ext;
   logic              neg, one, two;
   logic [PW-1:0]     pp;
   logic [PW-1:0]     acc_next;
   logic [XW:0]       mplr_next;
   logic              last_digit;
   logic              rest_zero;
   logic              finish;

   // Sign/zero extension; mcand is widened to the full product width so the
   // left shifts never lose weight that still lands inside the product.
   assign a_ext = sign ? {{(PW-WIDTH){a[WIDTH-1]}}, a} : {{(PW-WIDTH){1'b0}}, a};
   assign b_ext = sign ? {{2{b[WIDTH-1]}}, b}         : {2'b00, b};

   booth_enc u_enc (
      .bits (mplr[2:0]),
      .neg  (neg),
      .one  (one),
      .two  (two)
   );

   // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      pp = '0;
      if (two)
         pp = {mcand[PW-2:0], 1'b0};
      else if (one)
         pp = mcand;
      acc_next = neg ? (acc - pp) : (acc + pp);
   end

   assign mplr_next  = {{2{mplr[XW]}}, mplr[XW:2]};
   assign last_digit = (count == CW'(ND - 1));

`ifdef MUL_EARLY_TERM_EN
   // Post-shift window (including q-1) all equal means every remaining digit is zero.
   assign rest_zero = (&mplr_next[XW-1:0]) | ~(|mplr_next[XW-1:0]);
`else
   assign rest_zero = 1'b0;
`endif

   assign finish = last_digit | rest_zero;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= MUL_IDLE;
         ready  <= 1'b0;
         result <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplr   <= '0;
         count  <= '0;
      end else begin
         unique case (state)
            MUL_IDLE: begin
               if (start) begin
                  mcand <= a_ext;
                  mplr  <= {b_ext, 1'b0};
                  acc   <= '0;
                  count <= '0;
                  state <= MUL_BUSY;
               end
            end

            MUL_BUSY: begin
               if (!start) begin
                  // Annulled by the pipeline: drop the op, keep the old result.
                  state <= MUL_IDLE;
               end else begin
                  acc   <= acc_next;
                  mcand <= {mcand[PW-3:0], 2'b00};
                  mplr  <= mplr_next;
                  count <= count + CW'(1);
                  if (finish) begin
                     result <= acc_next;
                     ready  <= 1'b1;
                     state  <= MUL_DONE;
                  end
               end
            end

            MUL_DONE: begin
               ready <= 1'b0;
               state <= MUL_IDLE;
            end

            default: begin
               ready <= 1'b0;
               state <= MUL_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul.sv
// -----------------------------------------------------------------------------
// tb_booth_mul
//   Self-checking bench for booth_mul (WIDTH = 32). Honours MUL_EARLY_TERM_EN
//   for the expected latency of each operation.
// -----------------------------------------------------------------------------
module tb_booth_mul;

   localparam int W = 32;
   localparam int N = (W + 2) / 2;

`ifdef MUL_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic           clk;
   logic           rst;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           sign;
   logic           start;
   logic [2*W-1:0] result;
   logic           ready;

   booth_mul #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .sign   (sign),
      .start  (start),
      .result (result),
      .ready  (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           sign;
      logic [2*W-1:0] exp;
   } vec_t;

   typedef struct {
      logic [2*W-1:0] res;
      int             lat;
   } exp_t;

   exp_t           sb_q[$];
   logic [2*W-1:0] last_result;
   int             n_checks;
   int             n_pass;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
      logic signed [2*W-1:0] sp;
      logic        [2*W-1:0] up;
      sp = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
      up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      return s ? sp : up;
   endfunction

   // Cycles from first start to ready: digits needed + 1. With early
   // termination, the op stops after k digits once ext(b) >>> (2k-1) is 0 or -1.
   function automatic int exp_lat(input logic [W-1:0] y, input logic s);
      logic signed [W+1:0] eb;
      logic signed [W+1:0] t;
      eb = {(s ? {2{y[W-1]}} : 2'b00), y};
      if (!EARLY) return N + 1;
      for (int k = 1; k <= N; k++) begin
         t = eb >>> (2 * k - 1);
         if (t == '0 || t == '1) return k + 1;
      end
      return N + 1;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      next_cycle();
      rst = 1'b0;
      last_result = '0;
   endtask

   // One complete operation; begins with an IDLE cycle (also the cycle after a ready pulse).
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input string name);
      exp_t e;
      int   cyc;
      bit   got;
      next_cycle();
      check({name, " ready idle"}, 64'(ready), 64'd0);
      check({name, " result hold"}, result, last_result);
      a = x; b = y; sign = s; start = 1'b1;
      sb_q.push_back('{res: ref_mul(x, y, s), lat: exp_lat(y, s)});
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < N + 4) begin
         next_cycle();
         cyc++;
         if (ready) got = 1'b1;
      end
      start = 1'b0;
      e = sb_q.pop_front();
      if (!got) begin
         check({name, " ready timeout"}, 64'd0, 64'd1);
         do_reset();
      end else begin
         check({name, " result"}, result, e.res);
         check({name, " latency"}, 64'(cyc), 64'(e.lat));
         last_result = e.res;
      end
   endtask

   // Start an op, then drop start in cycle d (d must be before its ready cycle).
   task automatic run_abort(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                            input int d, input string name);
      bit seen;
      next_cycle();
      a = x; b = y; sign = s; start = 1'b1;
      seen = 1'b0;
      for (int i = 1; i <= d; i++) begin
         next_cycle();
         if (ready) seen = 1'b1;
      end
      start = 1'b0;
      repeat (3) begin
         next_cycle();
         if (ready) seen = 1'b1;
      end
      check({name, " no ready"}, 64'(seen), 64'd0);
      check({name, " result kept"}, result, last_result);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      int   d;
      int   lat;

      n_checks = 0;
      n_pass   = 0;
      a = '0; b = '0; sign = 1'b0; start = 1'b0;
      rst = 1'b1;
      last_result = '0;
      repeat (3) next_cycle();
      check("reset ready", 64'(ready), 64'd0);
      check("reset result", result, 64'd0);
      rst = 1'b0;

      // Directed table: {a, b, sign, expected product}
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
      vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
      vecs.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000});
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001});
      vecs.push_back('{32'h0000_0007, 32'h0000_0003, 1'b0, 64'h0000_0000_0000_0015});
      vecs.push_back('{32'h1234_5678, 32'h0000_0000, 1'b0, 64'h0000_0000_0000_0000});
      vecs.push_back('{32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB});
      vecs.push_back('{32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 64'h0000_0004_FFFF_FFFB});
      vecs.push_back('{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000});
      vecs.push_back('{32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6});
      for (int i = 0; i < vecs.size(); i++) begin
         // The scoreboard uses ref_mul; also hold it against the hand-computed table value.
         check($sformatf("vec%0d model", i), ref_mul(vecs[i].a, vecs[i].b, vecs[i].sign), vecs[i].exp);
         run_op(vecs[i].a, vecs[i].b, vecs[i].sign, $sformatf("vec%0d", i));
      end

      // Abort: 3*5, start dropped in cycle 5 (earlier if the op would already be done).
      lat = exp_lat(32'd5, 1'b0);
      d   = (lat - 1 < 5) ? lat - 1 : 5;
      run_abort(32'd3, 32'd5, 1'b0, d, "abort 3x5");
      run_op(32'd3, 32'd5, 1'b0, "restart 3x5");

      // Back-to-back: new op starts in the IDLE cycle right after ready.
      run_op(32'd3, 32'd5, 1'b0, "b2b first");
      run_op(32'hFFFF_FFF9, 32'd6, 1'b1, "b2b second");

      // Reset in cycle 9 of an op clears result and ready.
      next_cycle();
      a = 32'h1234_5678; b = 32'h9ABC_DEF0; sign = 1'b0; start = 1'b1;
      repeat (9) next_cycle();
      rst = 1'b1;
      start = 1'b0;
      next_cycle();
      check("mid-op reset ready", 64'(ready), 64'd0);
      check("mid-op reset result", result, 64'd0);
      rst = 1'b0;
      last_result = '0;
      run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "after reset");

      // Random ops with occasional annulment.
      for (int i = 0; i < 1500; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rs;
         ra = pick();
         rb = pick();
         rs = 1'($urandom_range(0, 1));
         lat = exp_lat(rb, rs);
         if ($urandom_range(0, 7) == 0 && lat > 1)
            run_abort(ra, rb, rs, $urandom_range(1, lat - 1), $sformatf("rnd%0d abort", i));
         else
            run_op(ra, rb, rs, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
